mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 ifReq  in  1  instruction-fetch read request; held until ifDone.
REQ-004 ifAddr  in  32  fetch byte address; always a 4-byte read.
REQ-005 ifClr  in  1  abort any pending/in-flight fetch (pipeline flush).
REQ-006 ifDone  out  1  one-cycle pulse; ifData valid in same cycle.
REQ-007 ifData  out  32  fetched word, little-endian.
REQ-008 lsReq  in  1  load/store request from the load-store unit; held until lsDone.
REQ-009 lsWrite  in  1  1 = store, 0 = load.
REQ-010 lsLen  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 and 3 = 4 bytes.
REQ-011 lsAddr  in  32  load/store byte address.
REQ-012 lsWdata  in  32  store data; low lsLen-size bytes used.
REQ-013 lsDone  out  1  one-cycle pulse; lsRdata valid in same cycle for loads.
REQ-014 lsRdata  out  32  load data, zero-extended; unused high bytes 0.
REQ-015 ramAddr  out  32  byte address to byte-wide synchronous RAM.
REQ-016 ramWr  out  1  1 = write ramDout at ramAddr this cycle.
REQ-017 ramDout  out  8  write byte.
REQ-018 ramDin  in  8  read byte; valid the cycle after its address is driven.

Function
REQ-019 FSM states: IDLE, IF_RD, LS_RD, LS_WR; one transaction at a time.
REQ-020 In IDLE, at a rising edge, sole requester is granted; if both request, grant goes to the requester not granted last (round-robin, 1-bit lastGrant).
REQ-021 Grant latches address, length (N = 1, 2 or 4; IF always 4), write data and direction; later changes of inputs are ignored.
REQ-022 Byte k (k = 0..N-1) maps to data[8k+7:8k] and address base+k, 32-bit wrap-around (0xFFFFFFFF + 1 = 0x00000000).
REQ-023 Read: grant at edge E0 drives ramAddr = base; E_k drives base+k for k<N; byte k captured at E_{k+1}; done pulse and data registered at E_N (word: done visible after E4, byte: after E1).
REQ-024 Write: ramWr=1 with ramAddr=base+k, ramDout=byte k in cycle after E_k, k = 0..N-1; ramWr=0 and lsDone=1 from E_N for one cycle.
REQ-025 FSM returns to IDLE at the edge that raises done; a new grant may occur at the next edge.
REQ-026 A requester whose done is high in the current cycle is ignored by arbitration at that cycle's closing edge (no double grant of a held req).
REQ-027 ifClr=1 in IF_RD: return to IDLE next edge, no ifDone, ramAddr holds last value; ifClr=1 in IDLE blocks ifReq for that edge.
REQ-028 ifClr never aborts LS_RD/LS_WR; stores are never abandoned once granted.
REQ-029 Outside transactions ramWr=0, ramDout=0, ifDone=lsDone=0; ifData/lsRdata hold last delivered value.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, lastGrant = IF (LS wins first tie), byte counter 0, ramAddr 0, ramWr 0, ramDout 0, ifDone 0, lsDone 0, ifData 0, lsRdata 0.
REQ-031 Reset mid-transaction abandons it without done pulse; ramWr drops in the same cycle reset asserts.

Structure
REQ-032 Shared package holds state encoding, lsLen codes, byte/word widths and address width.
REQ-033 One sub-module rr_arb2 (2-way round-robin with lastGrant register); remainder single module.

Verification
REQ-034 ifReq=1, ifAddr=0x10, RAM[0x10..0x13]=11,22,33,44 -> ramAddr 0x10..0x13 on consecutive cycles, ifDone one cycle after E4, ifData=0x44332211.
REQ-035 lsReq store lsLen=1, lsAddr=0x20, lsWdata=0xAABBCCDD -> ramWr two cycles, RAM[0x20]=DD, RAM[0x21]=CC, lsDone after E2, RAM[0x22] unchanged.
REQ-036 After reset, ifReq and lsReq rise same cycle -> LS granted first; IF granted on the edge after lsDone; repeat both held -> grants alternate.
REQ-037 Load lsLen=0 at 0xFFFFFFFF (byte 0x80), then word load at 0xFFFFFFFE -> lsRdata=0x00000080; second access addresses wrap to 0x00000000, 0x00000001.
REQ-038 ifClr pulsed in IF_RD second byte cycle, lsReq pending -> no ifDone, LS granted on following edge; rst=0 during LS_WR -> ramWr=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds state encoding, access-length codes and bus widths.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIfRd,
        StLsRd,
        StLsWr
    } state_e;

    typedef enum logic {
        GntIf = 1'b0,
        GntLs = 1'b1
    } gnt_e;

    // Codes 2 and 3 both mean a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
// Grants are combinational and only issued while enabled.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);

    gnt_e last_q;

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (en) begin
            if (req_if && req_ls) begin
                if (last_q == GntIf) begin
                    gnt_ls = 1'b1;
                end else begin
                    gnt_if = 1'b1;
                end
            end else begin
                gnt_if = req_if;
                gnt_ls = req_ls;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= GntIf;
        end else if (gnt_if) begin
            last_q <= GntIf;
        end else if (gnt_ls) begin
            last_q <= GntLs;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and load/store requests onto a byte-wide RAM,
// serialising each 1/2/4-byte access one byte per cycle, little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    input  logic              ifClr,
    output logic              ifDone,
    output logic [WORD_W-1:0] ifData,
    input  logic              lsReq,
    input  logic              lsWrite,
    input  logic [1:0]        lsLen,
    input  logic [ADDR_W-1:0] lsAddr,
    input  logic [WORD_W-1:0] lsWdata,
    output logic              lsDone,
    output logic [WORD_W-1:0] lsRdata,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWr,
    output logic [BYTE_W-1:0] ramDout,
    input  logic [BYTE_W-1:0] ramDin
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
    logic [2:0]        len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rd_buf_q, rd_buf_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [WORD_W-1:0] if_data_q, if_data_d;
    logic [WORD_W-1:0] ls_rdata_q, ls_rdata_d;

    logic       gnt_if, gnt_ls;
    logic       last_byte;
    logic [1:0] cnt_inc;

    // A requester whose done pulse is showing must not be re-granted on its held request.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == StIdle),
        .req_if (ifReq & ~ifClr & ~if_done_q),
        .req_ls (lsReq & ~ls_done_q),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    assign last_byte = ({1'b0, cnt_q} == (len_q - 3'd1));
    assign cnt_inc   = cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_wr_d   = 1'b0;
        ram_dout_d = '0;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_ls) begin
                    ram_addr_d = lsAddr;
                    len_d      = len_bytes(lsLen);
                    wdata_d    = lsWdata;
                    cnt_d      = '0;
                    rd_buf_d   = '0;
                    if (lsWrite) begin
                        state_d    = StLsWr;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = lsWdata[BYTE_W-1:0];
                    end else begin
                        state_d = StLsRd;
                    end
                end else if (gnt_if) begin
                    ram_addr_d = ifAddr;
                    len_d      = 3'd4;
                    cnt_d      = '0;
                    rd_buf_d   = '0;
                    state_d    = StIfRd;
                end
            end

            StIfRd, StLsRd: begin
                if (state_q == StIfRd && ifClr) begin
                    state_d = StIdle;
                end else begin
                    rd_buf_d[{cnt_q, 3'b000} +: BYTE_W] = ramDin;
                    if (last_byte) begin
                        state_d = StIdle;
                        if (state_q == StIfRd) begin
                            if_done_d = 1'b1;
                            if_data_d = rd_buf_d;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rd_buf_d;
                        end
                    end else begin
                        ram_addr_d = ram_addr_q + 1'b1;
                        cnt_d      = cnt_inc;
                    end
                end
            end

            StLsWr: begin
                if (last_byte) begin
                    state_d   = StIdle;
                    ls_done_d = 1'b1;
                end else begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = ram_addr_q + 1'b1;
                    ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: BYTE_W];
                    cnt_d      = cnt_inc;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rd_buf_q   <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rd_buf_q   <= rd_buf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign ramAddr = ram_addr_q;
    assign ramWr   = ram_wr_q;
    assign ramDout = ram_dout_q;
    assign ifDone  = if_done_q;
    assign ifData  = if_data_q;
    assign lsDone  = ls_done_q;
    assign lsRdata = ls_rdata_q;

endmodule
